// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one unbuffered UART transmitter among N requesters, one whole message
//   at a time. Grants are round-robin. Once a requester is granted, it keeps the
//   grant from its first byte through the byte flagged last. The block also
//   enforces the uart's write-then-busy handshake: after each uart_wr it spends
//   one clock ignoring uart_ready, then waits for uart_ready to return.
//
// Optional feature: define UART_ARB_TAG_EN to send a tag byte (8'h80 | owner)
// before each message. The tag byte is sent without an ack.
//
// Parameters
//   N        number of requesters (2..8)
//   TIMEOUT  idle clocks with the owner's req low in SEND before a forced release
//
// Ports
//   clk_i          system clock
//   arstn_i        asynchronous reset, active low
//   req_i[N]       requester i has a byte on data_i[8i+7:8i]
//   data_i[8N]     per-requester byte
//   last_i[N]      requester i's current byte ends its message
//   ack_o[N]       1-clk pulse: requester i's byte accepted
//   grant_o[N]     one-hot owner of the uart, 0 when idle
//   busy_o         a message is in progress
//   uart_ready_i   uart ready (drops the clock after uart_wr is sampled)
//   uart_wr_o      1-clk transmit strobe
//   uart_din_o     transmit byte
module uart_tx_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic           clk_i,
  input  logic           arstn_i,
  input  logic [N-1:0]   req_i,
  input  logic [8*N-1:0] data_i,
  input  logic [N-1:0]   last_i,
  output logic [N-1:0]   ack_o,
  output logic [N-1:0]   grant_o,
  output logic           busy_o,
  input  logic           uart_ready_i,
  output logic           uart_wr_o,
  output logic [7:0]     uart_din_o
);

  localparam int unsigned IdxW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StHold,
`ifdef UART_ARB_TAG_EN
    StWait,
    StTag
`else
    StWait
`endif
  } state_e;

  state_e          state_q;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] gidx_q;
  logic [N-1:0]    grant_q;
  logic            busy_q;
  logic [N-1:0]    ack_q;
  logic            wr_q;
  logic [7:0]      din_q;
  logic            last_q;
  logic [15:0]     cnt_q;
`ifdef UART_ARB_TAG_EN
  logic            tag_q;  // the byte in flight is a tag, not message data
`endif

  // Round-robin pick: first set req at or after ptr_q, wrapping N-1 -> 0.
  logic [IdxW-1:0] cand_idx;
  logic [IdxW-1:0] sel_idx;
  logic            sel_found;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_idx = IdxW'((32'(ptr_q) + k) % N);
      if (!sel_found && req_i[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Owner's request, byte and last flag.
  logic       req_g;
  logic       last_g;
  logic [7:0] data_g;

  always_comb begin
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gidx_q == IdxW'(i)) begin
        req_g  = req_i[i];
        last_g = last_i[i];
        data_g = data_i[8*i +: 8];
      end
    end
  end

  // After a release the finishing owner becomes lowest priority.
  logic [IdxW-1:0] ptr_next;
  logic [15:0]     cnt_inc;

  assign ptr_next = (gidx_q == IdxW'(N - 1)) ? '0 : gidx_q + IdxW'(1);
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef UART_ARB_TAG_EN
      tag_q   <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      wr_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (uart_ready_i && sel_found) begin
            gidx_q  <= sel_idx;
            grant_q <= N'(1) << sel_idx;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
`ifdef UART_ARB_TAG_EN
            state_q <= StTag;
`else
            state_q <= StSend;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        StTag: begin
          if (uart_ready_i) begin
            wr_q    <= 1'b1;
            din_q   <= 8'h80 | 8'(gidx_q);
            tag_q   <= 1'b1;
            state_q <= StHold;
          end
        end
`endif
        StSend: begin
          if (req_g) begin
            if (uart_ready_i) begin
              wr_q    <= 1'b1;
              din_q   <= data_g;
              ack_q   <= grant_q;
              last_q  <= last_g;
              cnt_q   <= '0;
              state_q <= StHold;
            end
          end else if (cnt_inc >= TimeoutVal) begin
            // Owner abandoned its message: force a release.
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_next;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        // uart_ready is stale here: the uart has not yet sampled uart_wr.
        StHold: state_q <= StWait;
        StWait: begin
          if (uart_ready_i) begin
`ifdef UART_ARB_TAG_EN
            if (tag_q) begin
              tag_q   <= 1'b0;
              state_q <= StSend;
            end else
`endif
            if (last_q) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              ptr_q   <= ptr_next;
              state_q <= StIdle;
            end else begin
              state_q <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign uart_wr_o  = wr_q;
  assign uart_din_o = din_q;

endmodule
